// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 round constants, IVs, FSM states and round functions
package sha2_pkg;

    typedef logic [0:7][31:0] sha2_words_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL
    } sha2_state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam sha2_words_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam sha2_words_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic sha2_words_t iv_words(input logic mode);
        return mode ? IV224 : IV256;
    endfunction

endpackage

// File: rtl/sha2_round.sv
// rtl/sha2_round.sv - one combinational SHA-2 compression round
module sha2_round
    import sha2_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] f,
    input  logic [31:0] g,
    input  logic [31:0] h,
    input  logic [31:0] kt,
    input  logic [31:0] wt,
    output logic [31:0] next_a,
    output logic [31:0] next_b,
    output logic [31:0] next_c,
    output logic [31:0] next_d,
    output logic [31:0] next_e,
    output logic [31:0] next_f,
    output logic [31:0] next_g,
    output logic [31:0] next_h
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + kt + wt;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign next_a = t1 + t2;
    assign next_b = a;
    assign next_c = b;
    assign next_d = c;
    assign next_e = d + t1;
    assign next_f = e;
    assign next_g = f;
    assign next_h = g;

endmodule

// File: rtl/sha2_core_p.sv
// rtl/sha2_core_p.sv - SHA-224/256 compression engine, RND_PER_CLK rounds per clock
module sha2_core_p
    import sha2_pkg::*;
#(
    parameter int RND_PER_CLK = 1,
    parameter bit SUPPORT_224 = 1'b1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_fStart,
    input  logic         i_fInit,
    input  logic         i_fMode,
    input  logic [511:0] i_Text,
    output logic         o_fReady,
    output logic         o_fDone,
    output logic [255:0] o_Text
);

    localparam int R = RND_PER_CLK;
    localparam logic [5:0] LAST_T = 6'(64 - R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rnd
        $error("sha2_core_p: RND_PER_CLK must be 1, 2, 4 or 8");
    end

    sha2_state_t state;
    sha2_state_t state_nxt;

    logic [31:0] w [16];
    logic [31:0] w_next [16];
    sha2_words_t wv;
    sha2_words_t hr;
    sha2_words_t h_sum;
    sha2_words_t rnd_out;
    logic [5:0]  t_cnt;
    logic        chain_valid;
    logic        mode;
    logic        mode_in;
    logic        load_iv;

    assign o_fReady = (state == ST_IDLE);
    assign mode_in  = SUPPORT_224 ? i_fMode : 1'b0;
    assign load_iv  = i_fInit | ~chain_valid;

    // Extend the window by R words so the next cycle starts at W[t+R].
    always_comb begin
        logic [31:0] x [16 + R];
        for (int i = 0; i < 16; i++) begin
            x[i] = w[i];
        end
        for (int j = 0; j < R; j++) begin
            x[16 + j] = small_sigma1(x[14 + j]) + x[9 + j] + small_sigma0(x[1 + j]) + x[j];
        end
        for (int i = 0; i < 16; i++) begin
            w_next[i] = x[R + i];
        end
    end

    for (genvar j = 0; j < R; j++) begin : g_rnd
        sha2_words_t vin;
        sha2_words_t vout;
        logic [5:0]  t_idx;

        assign t_idx = t_cnt + 6'(j);

        if (j == 0) begin : g_first
            assign vin = wv;
        end else begin : g_next
            assign vin = g_rnd[j - 1].vout;
        end

        sha2_round u_round (
            .a      (vin[0]),
            .b      (vin[1]),
            .c      (vin[2]),
            .d      (vin[3]),
            .e      (vin[4]),
            .f      (vin[5]),
            .g      (vin[6]),
            .h      (vin[7]),
            .kt     (K[t_idx]),
            .wt     (w[j]),
            .next_a (vout[0]),
            .next_b (vout[1]),
            .next_c (vout[2]),
            .next_d (vout[3]),
            .next_e (vout[4]),
            .next_f (vout[5]),
            .next_g (vout[6]),
            .next_h (vout[7])
        );
    end

    assign rnd_out = g_rnd[R - 1].vout;

    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = hr[i] + wv[i];
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_fStart) state_nxt = ST_ROUND;
            ST_ROUND: if (t_cnt == LAST_T) state_nxt = ST_FINAL;
            ST_FINAL: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
            wv          <= '0;
            hr          <= '0;
            t_cnt       <= '0;
            chain_valid <= 1'b0;
            mode        <= 1'b0;
            o_fDone     <= 1'b0;
            o_Text      <= '0;
        end else begin
            o_fDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_fStart) begin
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= i_Text[511 - 32*i -: 32];
                        end
                        // H is seeded with the IV too, so FINAL always adds into H.
                        if (load_iv) begin
                            wv   <= iv_words(mode_in);
                            hr   <= iv_words(mode_in);
                            mode <= mode_in;
                        end else begin
                            wv <= hr;
                        end
                        t_cnt <= '0;
                    end
                end
                ST_ROUND: begin
                    wv <= rnd_out;
                    for (int i = 0; i < 16; i++) begin
                        w[i] <= w_next[i];
                    end
                    if (t_cnt != LAST_T) begin
                        t_cnt <= t_cnt + 6'(R);
                    end
                end
                ST_FINAL: begin
                    hr          <= h_sum;
                    chain_valid <= 1'b1;
                    o_fDone     <= 1'b1;
                    if (mode) begin
                        o_Text <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                                   h_sum[4], h_sum[5], h_sum[6], 32'h0};
                    end else begin
                        o_Text <= h_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_core_p.sv
// tb/tb_sha2_core_p.sv - directed-vector bench for sha2_core_p
module tb_sha2_core_p;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   start = '0;
    logic         init = 1'b1;
    logic         mode = 1'b0;
    logic [511:0] text = '0;
    logic [3:0]   ready;
    logic [3:0]   done;
    logic [255:0] dig [4];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done[0]) done_cnt++;

    sha2_core_p #(.RND_PER_CLK(1), .SUPPORT_224(1'b1)) u_r1 (
        .i_Clk(clk), .i_Rst(rst), .i_fStart(start[0]), .i_fInit(init), .i_fMode(mode),
        .i_Text(text), .o_fReady(ready[0]), .o_fDone(done[0]), .o_Text(dig[0]));
    sha2_core_p #(.RND_PER_CLK(2), .SUPPORT_224(1'b1)) u_r2 (
        .i_Clk(clk), .i_Rst(rst), .i_fStart(start[1]), .i_fInit(init), .i_fMode(mode),
        .i_Text(text), .o_fReady(ready[1]), .o_fDone(done[1]), .o_Text(dig[1]));
    sha2_core_p #(.RND_PER_CLK(4), .SUPPORT_224(1'b1)) u_r4 (
        .i_Clk(clk), .i_Rst(rst), .i_fStart(start[2]), .i_fInit(init), .i_fMode(mode),
        .i_Text(text), .o_fReady(ready[2]), .o_fDone(done[2]), .o_Text(dig[2]));
    sha2_core_p #(.RND_PER_CLK(8), .SUPPORT_224(1'b1)) u_r8 (
        .i_Clk(clk), .i_Rst(rst), .i_fStart(start[3]), .i_fInit(init), .i_fMode(mode),
        .i_Text(text), .o_fReady(ready[3]), .o_fDone(done[3]), .o_Text(dig[3]));

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DG_ABC256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_ABC224 =
        256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] DG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge while instance k is ready; returns digest and
    // the number of edges from the accepting edge to the one raising o_fDone.
    task automatic run_block(input int k, input logic [511:0] blk, input logic fi,
                             input logic fm, output logic [255:0] d, output int lat);
        text     = blk;
        init     = fi;
        mode     = fm;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        lat = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done[k]) break;
        end
        d = dig[k];
    endtask

    logic [255:0] d;
    int lat;
    int base;
    int ok;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 256'(ready[0]), 256'(1));
        check("reset_done", 256'(done[0]), 256'(0));
        check("reset_text", dig[0], 256'h0);
        rst = 1'b0;

        run_block(0, BLK_ABC, 1'b1, 1'b0, d, lat);
        check("abc256_digest", d, DG_ABC256);
        check("abc256_latency", 256'(lat), 256'(65));

        run_block(0, BLK_ABC, 1'b1, 1'b1, d, lat);
        check("abc224_digest", d, DG_ABC224);

        base = done_cnt;
        run_block(0, BLK_TWO1, 1'b1, 1'b0, d, lat);
        check("two_blk1_latency", 256'(lat), 256'(65));
        check("two_ready_in_done", 256'(ready[0]), 256'(1));
        run_block(0, BLK_TWO2, 1'b0, 1'b1, d, lat);
        check("two_blk2_latency", 256'(lat), 256'(65));
        check("two_digest", d, DG_TWO);
        @(negedge clk);
        check("two_done_count", 256'(done_cnt - base), 256'(2));
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) begin
            run_block(k, BLK_EMPTY, 1'b1, 1'b0, d, lat);
            check($sformatf("empty_digest_r%0d", 1 << k), d, DG_EMPTY);
            check($sformatf("empty_latency_r%0d", 1 << k), 256'(lat), 256'(64 / (1 << k) + 1));
            @(posedge clk);
            #1;
        end

        base = done_cnt;
        text = BLK_ABC;
        init = 1'b1;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        text = BLK_EMPTY;
        mode = 1'b1;
        start[0] = 1'b1;
        check("busy_ready_low", 256'(ready[0]), 256'(0));
        repeat (5) @(posedge clk);
        #1;
        start[0] = 1'b0;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                ok = 1;
                break;
            end
        end
        check("busy_done_seen", 256'(ok), 256'(1));
        check("busy_ignored_digest", dig[0], DG_ABC256);
        repeat (70) @(posedge clk);
        #1;
        check("busy_done_count", 256'(done_cnt - base), 256'(1));

        base = done_cnt;
        text = BLK_ABC;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 256'(ready[0]), 256'(1));
        check("abort_done", 256'(done[0]), 256'(0));
        check("abort_text", dig[0], 256'h0);
        @(posedge clk);
        #1;
        check("rst_start_ready", 256'(ready[0]), 256'(1));
        start[0] = 1'b0;
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("abort_no_done", 256'(done_cnt - base), 256'(0));

        run_block(0, BLK_ABC, 1'b0, 1'b0, d, lat);
        check("post_rst_chain_digest", d, DG_ABC256);
        check("post_rst_latency", 256'(lat), 256'(65));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
